uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
Parametrised successor to the fixed 8N2 UART transmitter. Adds compile-time data-bit and stop-bit counts, a run-time baud divisor with a compile-time default, a valid/ready input handshake, back-to-back frames with no gap, and optional parity. Sits between command/telemetry logic and the rover serial TX pins. Drives txd directly from a register.

Parameters:
CLK_FREQ, 100_000_000, clock frequency in Hz.
BAUD, 9600, baud used for the default divisor DEF_DIV = (CLK_FREQ + BAUD/2) / BAUD.
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
STOP_BITS, 1, stop bits per frame; 1 or 2.
DIV_W, 16, width of div_cfg and of the bit-period counter.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  block can accept a frame.
tx_data  in  DATA_BITS  frame payload.
div_cfg  in  DIV_W  clocks per bit; a value < 2 selects DEF_DIV.
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
tx_busy  out  1  frame in progress; equals ~tx_ready.
frame_done  out  1  one-cycle pulse at the end of the last stop bit.
txd  out  1  serial line; idles high.

Behaviour:
- Reset (async assert, sync release): txd=1, tx_ready=1, tx_busy=0, frame_done=0, FSM=IDLE, counters=0. Asserting reset mid-frame aborts the frame and drives txd high immediately. No partial frame resumes after reset.
- Accept cycle A is any cycle with tx_valid & tx_ready.
  - In cycle A the block latches tx_data, parity_mode and the effective divisor D.
  - tx_ready falls in cycle A+1.
  - Changes on tx_data, div_cfg or parity_mode after cycle A do not affect the current frame.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or -> START directly when a new frame is accepted.
  - Each bit is held for exactly D clocks, timed by a down-counter reloaded with D-1.
  - DATA runs DATA_BITS bits, LSB first, tracked by a bit index that is not wrapped.
  - STOP runs STOP_BITS bit periods.
- txd is registered. The start bit (0) is on txd in cycles A+1 .. A+D.
- Frame length F = D * (1 + DATA_BITS + P + STOP_BITS), where P = 1 only if the parity bit is present.
- In cycle A+F: tx_ready=1 and frame_done=1. The last stop bit is still on txd in that cycle.
  - If tx_valid is also high in A+F, the next start bit begins in A+F+1. Frames are contiguous with zero idle.
- tx_valid high while busy has no effect, and data is not queued.
- D is computed in DIV_W bits. DEF_DIV must fit in DIV_W; an elaboration-time check fails the build otherwise.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: if parity_mode is 01 or 10, a PARITY state follows DATA for one bit period.
  - Even: the bit is the XOR of the data bits.
  - Odd: the bit is the inverse of that XOR.
  - With modes 00/11 the PARITY state is skipped.
- Not defined: no PARITY state or XOR logic is synthesised, parity_mode is ignored, and P = 0 always. The port remains so the interface is unchanged.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - function calc_div(clk_freq, baud) returning the rounded divisor.
  - The future uart_rx_param shares this package.
- One sub-module, uart_baud_div:
  - loadable DIV_W down-counter with inputs load, div, en, and output bit_tick (last cycle of each bit period);
  - reusable by the RX side.

Test Plan:
1. Reset: hold rst_n=0 with tx_valid=1 -> txd=1, tx_ready=1, frame_done=0. Release reset -> nothing is sent until an accept cycle.
2. 8N1, div_cfg=4, tx_data=0xA5 accepted at A -> txd (4 clocks per bit) = 0,1,0,1,0,0,1,0,1,1. tx_ready rises and frame_done pulses at A+40.
3. Back-to-back 0x55 then 0x0F, tx_valid held high, div_cfg=4 -> second start bit at A+41. No idle cycle; 20 bits total at 4 clocks each.
4. UART_TX_PARITY_EN defined, tx_data=0x07, div_cfg=4:
   - even mode -> parity bit 1, F=44;
   - odd mode -> parity bit 0;
   - mode 11 -> no parity bit, F=40.
   - Macro undefined -> F=40 for every mode.
5. Mid-frame changes: at A+10, change tx_data to 0xFF and div_cfg to 8 -> the frame is unchanged (D=4). The next frame uses D=8.
6. Reset mid-frame: assert rst_n=0 at A+15 during DATA -> txd=1 in the same cycle, tx_ready=1. After release, a new 0x3C frame is sent cleanly. div_cfg=0 selects DEF_DIV=10417 at the defaults.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the parametrised TX and the future RX side.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Rounded clocks-per-bit divisor.
  function automatic int unsigned calc_div(input longint unsigned clk_freq,
                                           input longint unsigned baud);
    return 32'((clk_freq + baud / 2) / baud);
  endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Loadable bit-period down-counter; bit_tick marks the last clock of each bit period.
module uart_baud_div #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             en,
  output logic             bit_tick
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign bit_tick = en && (cnt_q == '0);

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      div_d = div;
      cnt_d = div - 1'b1;
    end else if (bit_tick) begin
      cnt_d = div_q - 1'b1;
    end else if (en) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input and contiguous frames.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [DIV_W-1:0]     div_cfg,
  input  logic [1:0]           parity_mode,
  output logic                 tx_busy,
  output logic                 frame_done,
  output logic                 txd
);

  localparam int unsigned     DEF_DIV   = calc_div(CLK_FREQ, BAUD);
  localparam longint unsigned DIV_LIMIT = 64'd1 << DIV_W;

  if (64'(DEF_DIV) >= DIV_LIMIT) begin : g_def_div_check
    $error("DEF_DIV does not fit in DIV_W bits");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_bits_check
    $error("DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_bits_check
    $error("STOP_BITS must be 1 or 2");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [3:0]           idx_q, idx_d;
  logic                 txd_q, txd_d;
  logic [DIV_W-1:0]     eff_div;
  logic                 bit_tick;
  logic                 accept;
  logic                 last_stop;
  logic                 go_parity;
  logic                 par_bit;

  assign eff_div    = (div_cfg < DIV_W'(2)) ? DIV_W'(DEF_DIV) : div_cfg;
  assign last_stop  = (state_q == StStop) && bit_tick && (idx_q == 4'(STOP_BITS - 1));
  assign tx_ready   = (state_q == StIdle) || last_stop;
  assign tx_busy    = ~tx_ready;
  assign frame_done = last_stop;
  assign accept     = tx_valid && tx_ready;
  assign txd        = txd_q;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (accept) begin
      par_en_q  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      par_bit_q <= (^tx_data) ^ (parity_mode == PAR_ODD);
    end
  end

  assign go_parity = par_en_q;
  assign par_bit   = par_bit_q;
`else
  logic unused_parity_mode;

  assign unused_parity_mode = ^parity_mode;
  assign go_parity          = 1'b0;
  assign par_bit            = 1'b1;
`endif

  uart_baud_div #(
    .DIV_W(DIV_W)
  ) u_baud_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .div     (eff_div),
    .en      (state_q != StIdle),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    txd_d   = txd_q;
    case (state_q)
      StIdle: begin
        txd_d = 1'b1;
      end
      StStart: begin
        if (bit_tick) begin
          state_d = StData;
          txd_d   = data_q[0];
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_tick) begin
          if (idx_q == 4'(DATA_BITS - 1)) begin
            idx_d = '0;
            if (go_parity) begin
              state_d = StParity;
              txd_d   = par_bit;
            end else begin
              state_d = StStop;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = data_q >> 1;
            txd_d  = data_q[1];
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          state_d = StStop;
          txd_d   = 1'b1;
          idx_d   = '0;
        end
      end
      StStop: begin
        if (bit_tick) begin
          if (last_stop) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase
    // A new accept overrides the stop-bit exit so frames run back to back.
    if (accept) begin
      state_d = StStart;
      data_d  = tx_data;
      idx_d   = '0;
      txd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
    end
  end

endmodule
